// File: rtl/outmem_readout.sv
// Readback engine for a layer output memory: walks every (channel,row,col) index,
// absorbs the 1-cycle read latency and streams index-tagged words to the host.
module outmem_readout #(
    parameter int DATA_SIZE    = 64,
    parameter int NUM_CHANNELS = 32,
    parameter int OUTPUT_DIM   = 11,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 mem_read_en,
    output logic [15:0]          mem_read_index [3],
    input  logic [DATA_SIZE-1:0] mem_read_data,
    output logic [DATA_SIZE-1:0] out_data,
    output logic [15:0]          out_index [3],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);
    localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [15:0]      LAST_CH  = 16'(NUM_CHANNELS - 1);
    localparam logic [15:0]      LAST_DIM = 16'(OUTPUT_DIM - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t               r_state;
    logic [15:0]          r_ch;
    logic [15:0]          r_row;
    logic [15:0]          r_col;
    logic                 r_busy;
    logic                 r_done;

    // Tag pipeline: follows each read by one cycle so it lines up with mem_read_data.
    logic                 r_rd_valid;
    logic [47:0]          r_rd_index;
    logic                 r_rd_last;

    logic [DATA_SIZE-1:0] r_fifo_data  [FIFO_DEPTH];
    logic [47:0]          r_fifo_index [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_last;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic                 w_last_idx;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_final;
    logic [CNT_W:0]       w_occupancy;
    logic [47:0]          w_cur_index;
    logic [47:0]          w_head_index;

    assign w_cur_index  = {r_ch, r_row, r_col};
    assign w_last_idx   = (r_ch == LAST_CH) && (r_row == LAST_DIM) && (r_col == LAST_DIM);
    // Credit check counts the read still in flight, so a push can never find the FIFO full.
    assign w_occupancy  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_rd_valid};
    assign w_issue      = (r_state == S_RUN) && (w_occupancy < DEPTH_C);
    assign w_push       = r_rd_valid;
    assign w_pop        = out_valid && out_ready;
    assign w_final      = w_pop && out_last;
    assign w_head_index = r_fifo_index[r_rd_ptr];

    assign mem_read_en = w_issue;
    assign out_valid   = (r_count != '0);
    assign out_data    = r_fifo_data[r_rd_ptr];
    assign out_last    = r_fifo_last[r_rd_ptr];
    assign busy        = r_busy;
    assign done        = r_done;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_index
            assign mem_read_index[gi] = w_cur_index[16*gi +: 16];
            assign out_index[gi]      = w_head_index[16*gi +: 16];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_ch    <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        if (w_last_idx) begin
                            r_ch    <= '0;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_state <= S_DRAIN;
                        end else if (r_col == LAST_DIM) begin
                            r_col <= '0;
                            if (r_row == LAST_DIM) begin
                                r_row <= '0;
                                r_ch  <= r_ch + 16'd1;
                            end else begin
                                r_row <= r_row + 16'd1;
                            end
                        end else begin
                            r_col <= r_col + 16'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_final) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_index <= '0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rd_valid <= w_issue;
            if (w_issue) begin
                r_rd_index <= w_cur_index;
                r_rd_last  <= w_last_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr]  <= mem_read_data;
            r_fifo_index[r_wr_ptr] <= r_rd_index;
            r_fifo_last[r_wr_ptr]  <= r_rd_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_MAX) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_MAX) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end
endmodule
